mult_div_sequencer: RTL and testbench

- Multi-cycle controller for the CPU's MULT/MULTU/DIV/DIVU instructions. Owns the architectural HI/LO registers.
- Sequences a radix-2 shift-add multiplier and a restoring divider over 32 iterations.
- The CPU core issues operations through a start/busy handshake and reads HI/LO for MFHI/MFLO.
- Sits beside the ALU in the execute stage; the core stalls MFHI/MFLO/issue while busy=1.

---
 rtl/mips_muldiv_pkg.sv | 31 +++
 rtl/mult_div_sequencer_if.sv | 30 +++
 rtl/muldiv_step.sv | 39 +++
 rtl/mult_div_sequencer.sv | 144 ++++++++++++++
 tb/tb_mult_div_sequencer.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/mips_muldiv_pkg.sv
// rtl/mips_muldiv_pkg.sv - shared types and constants for the MULT/DIV sequencer
package mips_muldiv_pkg;

    // Operand/HI/LO width and iteration count; one quotient/product bit per iteration.
    localparam int MD_WIDTH = 32;
    localparam int MD_ITERS = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PREP = 2'b01,
        ITER = 2'b10,
        FIX  = 2'b11
    } state_e;

    // MULT and DIV are the signed variants (op bit 0 clear).
    function automatic logic op_is_signed(input op_e op);
        return ~op[0];
    endfunction

    function automatic logic op_is_div(input op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/mult_div_sequencer_if.sv
// rtl/mult_div_sequencer_if.sv - issue/result bundle between the CPU core and the MULT/DIV sequencer
interface mult_div_sequencer_if #(
    parameter int WIDTH = mips_muldiv_pkg::MD_WIDTH
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // Core side: issues operations and MTHI/MTLO, reads HI/LO.
    modport master (
        output start, op, op_a, op_b, mthi, mtlo, wdata,
        input  busy, done, div_by_zero, hi, lo
    );

    // Sequencer side.
    modport slave (
        input  start, op, op_a, op_b, mthi, mtlo, wdata,
        output busy, done, div_by_zero, hi, lo
    );

endinterface

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one combinational iteration of shift-add multiply or restoring divide
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_upper,    // product upper half / partial remainder
    input  logic [WIDTH-1:0] i_lower,    // multiplier bits / dividend bits shifting into quotient
    input  logic [WIDTH-1:0] i_operand,  // multiplicand / divisor magnitude
    output logic [WIDTH-1:0] o_upper,
    output logic [WIDTH-1:0] o_lower
);

    // Multiply: the add keeps its carry in bit WIDTH so the right shift never loses it.
    logic [WIDTH:0] w_sum;
    // Divide: remainder shifted left with the next dividend bit; it is always below
    // 2*divisor, so bit WIDTH of the difference is a reliable sign.
    logic [WIDTH:0] w_rsh;
    logic [WIDTH:0] w_diff;
    logic           w_fit;

    assign w_sum  = {1'b0, i_upper} + (i_lower[0] ? {1'b0, i_operand} : {(WIDTH+1){1'b0}});
    assign w_rsh  = {i_upper, i_lower[WIDTH-1]};
    assign w_diff = w_rsh - {1'b0, i_operand};
    assign w_fit  = ~w_diff[WIDTH];

    // Select the next upper/lower pair for the active operation.
    always_comb begin
        o_upper = i_upper;
        o_lower = i_lower;
        if (i_is_div) begin
            o_upper = w_fit ? w_diff[WIDTH-1:0] : w_rsh[WIDTH-1:0];
            o_lower = {i_lower[WIDTH-2:0], w_fit};
        end else begin
            o_upper = w_sum[WIDTH:1];
            o_lower = {w_sum[0], i_lower[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_sequencer.sv
// rtl/mult_div_sequencer.sv - multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO
module mult_div_sequencer
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int ITERS = MD_ITERS    // must equal WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    mult_div_sequencer_if.slave   bus
);

    localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;

    state_e             r_state;
    op_e                r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_operand;
    logic [WIDTH-1:0]   r_upper;
    logic [WIDTH-1:0]   r_lower;
    logic [CNT_W-1:0]   r_count;
    logic               r_neg_res;   // product sign, or quotient sign
    logic               r_neg_rem;   // remainder sign (follows the dividend)
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;
    logic               r_dbz;

    logic               w_signed;
    logic               w_is_div;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH-1:0]   w_step_upper;
    logic [WIDTH-1:0]   w_step_lower;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quot_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_signed = op_is_signed(r_op);
    assign w_is_div = op_is_div(r_op);

    // Magnitudes for signed ops; -0x80000000 wraps to itself, which is the correct unsigned magnitude.
    assign w_abs_a = (w_signed && r_a[WIDTH-1]) ? -r_a : r_a;
    assign w_abs_b = (w_signed && r_b[WIDTH-1]) ? -r_b : r_b;

    assign w_prod     = {r_upper, r_lower};
    assign w_prod_fix = r_neg_res ? -w_prod : w_prod;
    assign w_quot_fix = r_neg_res ? -r_lower : r_lower;
    assign w_rem_fix  = r_neg_rem ? -r_upper : r_upper;

    muldiv_step #(
        .WIDTH     (WIDTH)
    ) u_step (
        .i_is_div  (w_is_div),
        .i_upper   (r_upper),
        .i_lower   (r_lower),
        .i_operand (r_operand),
        .o_upper   (w_step_upper),
        .o_lower   (w_step_lower)
    );

    // Sequencer FSM: latch, prepare magnitudes, iterate, then sign-fix and commit HI/LO.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_op      <= OP_MULT;
            r_a       <= '0;
            r_b       <= '0;
            r_operand <= '0;
            r_upper   <= '0;
            r_lower   <= '0;
            r_count   <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dbz     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            case (r_state)
                IDLE: begin
                    // MT writes land now; a coincident op overwrites both registers at FIX.
                    if (bus.mthi) r_hi <= bus.wdata;
                    if (bus.mtlo) r_lo <= bus.wdata;
                    if (bus.start) begin
                        r_op    <= op_e'(bus.op);
                        r_a     <= bus.op_a;
                        r_b     <= bus.op_b;
                        r_busy  <= 1'b1;
                        r_state <= PREP;
                    end
                end
                PREP: begin
                    r_operand <= w_is_div ? w_abs_b : w_abs_a;
                    r_lower   <= w_is_div ? w_abs_a : w_abs_b;
                    r_upper   <= '0;
                    r_neg_res <= w_signed & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
                    r_neg_rem <= w_signed & r_a[WIDTH-1];
                    r_count   <= CNT_W'(ITERS - 1);
                    r_state   <= ITER;
                end
                ITER: begin
                    r_upper <= w_step_upper;
                    r_lower <= w_step_lower;
                    if (r_count == '0) begin
                        r_state <= FIX;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
                FIX: begin
                    if (w_is_div) begin
                        if (r_operand == '0) begin
                            r_dbz <= 1'b1;
                        end else begin
                            r_hi <= w_rem_fix;
                            r_lo <= w_quot_fix;
                        end
                    end else begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_dbz;
    assign bus.hi          = r_hi;
    assign bus.lo          = r_lo;

endmodule

// File: tb/tb_mult_div_sequencer.sv
// tb/tb_mult_div_sequencer.sv - self-checking bench for mult_div_sequencer
module tb_mult_div_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mult_div_sequencer_if bus ();

    mult_div_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference: plain 64-bit arithmetic; SV division truncates and % follows the dividend.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] hi0, input logic [31:0] lo0);
        longint sa, sb, ua, ub, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (op)
            2'd0: begin p = sa * sb; return p; end
            2'd1: begin p = ua * ub; return p; end
            2'd2: begin
                if (b == 32'd0) return {hi0, lo0};
                q = sa / sb; r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {hi0, lo0};
                q = ua / ub; r = ua % ub;
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1; bus.op = op; bus.op_a = a; bus.op_b = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (bus.busy === 1'b1 && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic do_mt(input logic hi_en, input logic lo_en, input logic [31:0] d);
        bus.mthi = hi_en; bus.mtlo = lo_en; bus.wdata = d;
        @(negedge clk);
        bus.mthi = 1'b0; bus.mtlo = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        @(negedge clk);
        n_tests += 5;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
        if (bus.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz got %b want 0", bus.div_by_zero); end
        if (bus.hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi got %h want 0", bus.hi); end
        if (bus.lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo got %h want 0", bus.lo); end
        reset = 1'b0;
    endtask

    task automatic test_directed;
        logic [1:0]  t_op [5];
        logic [31:0] t_a [5], t_b [5], t_hi [5], t_lo [5];
        int cyc;
        t_op = '{2'd1, 2'd0, 2'd2, 2'd3, 2'd2};
        t_a  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'h80000000};
        t_b  = '{32'h00000002, 32'h00000002, 32'h00000002, 32'h00000010, 32'hFFFFFFFF};
        t_hi = '{32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0000000F, 32'h00000000};
        t_lo = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h0FFFFFFF, 32'h80000000};
        for (int i = 0; i < 5; i++) begin
            issue(t_op[i], t_a[i], t_b[i]);
            wait_done(cyc);
            n_tests += 6;
            if (cyc !== 34) begin n_fail++; $display("FAIL dir%0d_busy_cycles got %0d want 34", i, cyc); end
            if (bus.done !== 1'b1) begin n_fail++; $display("FAIL dir%0d_done got %b want 1", i, bus.done); end
            if (bus.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL dir%0d_dbz got %b want 0", i, bus.div_by_zero); end
            if (bus.hi !== t_hi[i]) begin n_fail++; $display("FAIL dir%0d_hi got %h want %h", i, bus.hi, t_hi[i]); end
            if (bus.lo !== t_lo[i]) begin n_fail++; $display("FAIL dir%0d_lo got %h want %h", i, bus.lo, t_lo[i]); end
            @(negedge clk);
            if (bus.done !== 1'b0) begin n_fail++; $display("FAIL dir%0d_done_pulse got %b want 0", i, bus.done); end
        end
    endtask

    task automatic test_mt_with_start;
        int cyc;
        bus.start = 1'b1; bus.op = 2'd1; bus.op_a = 32'd3; bus.op_b = 32'd5;
        bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wdata = 32'hA5A5A5A5;
        @(negedge clk);
        bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
        n_tests += 5;
        if (bus.hi !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL mt_first_hi got %h want a5a5a5a5", bus.hi); end
        if (bus.lo !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL mt_first_lo got %h want a5a5a5a5", bus.lo); end
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL mt_busy got %b want 1", bus.busy); end
        wait_done(cyc);
        if (bus.hi !== 32'h0) begin n_fail++; $display("FAIL mt_over_hi got %h want 0", bus.hi); end
        if (bus.lo !== 32'd15) begin n_fail++; $display("FAIL mt_over_lo got %h want f", bus.lo); end
        @(negedge clk);
    endtask

    task automatic test_div_by_zero;
        int cyc;
        do_mt(1'b1, 1'b0, 32'h12345678);
        do_mt(1'b0, 1'b1, 32'h9ABCDEF0);
        n_tests += 2;
        if (bus.hi !== 32'h12345678) begin n_fail++; $display("FAIL mthi got %h want 12345678", bus.hi); end
        if (bus.lo !== 32'h9ABCDEF0) begin n_fail++; $display("FAIL mtlo got %h want 9abcdef0", bus.lo); end
        issue(2'd3, 32'd5, 32'd0);
        cyc = 0;
        while (bus.busy === 1'b1 && cyc < 200) begin
            if (cyc == 5) begin
                bus.start = 1'b1; bus.op = 2'd1; bus.op_a = 32'd7; bus.op_b = 32'd7;
                bus.mthi = 1'b1; bus.wdata = 32'hDEADBEEF;
            end
            if (cyc == 6) begin
                bus.start = 1'b0; bus.mthi = 1'b0;
                n_tests++;
                if (bus.hi !== 32'h12345678) begin n_fail++; $display("FAIL busy_mthi got %h want 12345678", bus.hi); end
            end
            cyc++;
            @(negedge clk);
        end
        n_tests += 7;
        if (cyc !== 34) begin n_fail++; $display("FAIL dbz_busy_cycles got %0d want 34", cyc); end
        if (bus.done !== 1'b1) begin n_fail++; $display("FAIL dbz_done got %b want 1", bus.done); end
        if (bus.div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dbz_flag got %b want 1", bus.div_by_zero); end
        if (bus.hi !== 32'h12345678) begin n_fail++; $display("FAIL dbz_hi got %h want 12345678", bus.hi); end
        if (bus.lo !== 32'h9ABCDEF0) begin n_fail++; $display("FAIL dbz_lo got %h want 9abcdef0", bus.lo); end
        @(negedge clk);
        if (bus.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL dbz_pulse got %b want 0", bus.div_by_zero); end
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL ignored_start_busy got %b want 0", bus.busy); end
    endtask

    task automatic test_reset_mid;
        int cyc;
        bit saw_done;
        logic [63:0] exp;
        issue(2'd0, 32'h00001234, 32'hFFFFFFFD);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_tests += 5;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", bus.busy); end
        if (bus.hi !== 32'h0) begin n_fail++; $display("FAIL rstmid_hi got %h want 0", bus.hi); end
        if (bus.lo !== 32'h0) begin n_fail++; $display("FAIL rstmid_lo got %h want 0", bus.lo); end
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done = 1'b1;
            @(negedge clk);
        end
        if (saw_done !== 1'b0) begin n_fail++; $display("FAIL rstmid_activity got 1 want 0"); end
        issue(2'd0, 32'h00001234, 32'hFFFFFFFD);
        wait_done(cyc);
        exp = model(2'd0, 32'h00001234, 32'hFFFFFFFD, 32'h0, 32'h0);
        if ({bus.hi, bus.lo} !== exp) begin n_fail++; $display("FAIL rstmid_after got %h want %h", {bus.hi, bus.lo}, exp); end
        @(negedge clk);
    endtask

    task automatic test_random_back_to_back;
        logic [31:0] m_hi, m_lo, a, b;
        logic [1:0]  op;
        logic [63:0] exp;
        int cyc, mode;
        m_hi = $urandom; m_lo = $urandom;
        do_mt(1'b1, 1'b1, m_hi);
        m_lo = m_hi;
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            a = $urandom;
            mode = $urandom_range(0, 7);
            case (mode)
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = 32'hFFFFFFFF;
                3: begin a = 32'h80000000; b = $urandom; end
                default: b = $urandom;
            endcase
            exp = model(op, a, b, m_hi, m_lo);
            {m_hi, m_lo} = exp;
            issue(op, a, b);
            wait_done(cyc);
            n_tests += 4;
            if (cyc !== 34) begin n_fail++; $display("FAIL rnd%0d_busy_cycles got %0d want 34", i, cyc); end
            if (bus.done !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_done got %b want 1", i, bus.done); end
            if (bus.div_by_zero !== (op[1] && b == 32'd0)) begin
                n_fail++; $display("FAIL rnd%0d_dbz got %b want %b", i, bus.div_by_zero, (op[1] && b == 32'd0));
            end
            if ({bus.hi, bus.lo} !== exp) begin
                n_fail++; $display("FAIL rnd%0d_hilo op %0d a %h b %h got %h want %h", i, op, a, b, {bus.hi, bus.lo}, exp);
            end
            // Odd iterations issue the next op in the done cycle; even ones idle one cycle.
            if (i % 2 == 0) begin
                @(negedge clk);
                n_tests++;
                if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_done_clear got %b want 0", i, bus.done); end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        bus.start = 1'b0; bus.op = 2'd0; bus.op_a = '0; bus.op_b = '0;
        bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.wdata = '0;
        test_reset();
        test_directed();
        test_mt_with_start();
        test_div_by_zero();
        test_reset_mid();
        test_random_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout reached at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
